// File: rtl/piso_serializer.sv
// Parallel-in serial-out transmitter with valid/ready load and gap-free back-to-back frames.
// Optional even-parity trailer bit enabled by defining PISO_PARITY_EN.
module piso_serializer #(
    parameter int unsigned WIDTH     = 8,
    parameter int unsigned MSB_FIRST = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] din,
    input  logic             load_valid,
    output logic             load_ready,
    output logic             q,
    output logic             q_valid,
    output logic             q_last
);

`ifdef PISO_PARITY_EN
    localparam int unsigned FRAME_LEN = WIDTH + 1;
`else
    localparam int unsigned FRAME_LEN = WIDTH;
`endif
    localparam int unsigned CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST_IDX = CW'(FRAME_LEN - 1);

    localparam logic [0:0] IDLE  = 1'b0;
    localparam logic [0:0] SHIFT = 1'b1;

    logic [0:0]       state;
    logic [WIDTH-1:0] shreg;
    logic [CW-1:0]    cnt;
    logic [CW-1:0]    cnt_next;
    logic             accept;
    logic             first_bit;
    logic             next_bit;
    logic [WIDTH-1:0] load_rest;
    logic [WIDTH-1:0] shift_rest;
`ifdef PISO_PARITY_EN
    logic             parity;
`endif

    assign load_ready = (state == IDLE) || ((state == SHIFT) && (cnt == LAST_IDX));
    assign accept     = load_valid && load_ready;
    assign cnt_next   = cnt + CW'(1);

    // The first bit goes straight to q on accept, so the shift register only
    // holds the bits still to be sent.
    always_comb begin
        first_bit  = 1'b0;
        next_bit   = 1'b0;
        load_rest  = '0;
        shift_rest = '0;
        if (MSB_FIRST != 0) begin
            first_bit  = din[WIDTH-1];
            load_rest  = {din[WIDTH-2:0], 1'b0};
            next_bit   = shreg[WIDTH-1];
            shift_rest = {shreg[WIDTH-2:0], 1'b0};
        end else begin
            first_bit  = din[0];
            load_rest  = {1'b0, din[WIDTH-1:1]};
            next_bit   = shreg[0];
            shift_rest = {1'b0, shreg[WIDTH-1:1]};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            shreg   <= '0;
            cnt     <= '0;
            q       <= 1'b0;
            q_valid <= 1'b0;
            q_last  <= 1'b0;
`ifdef PISO_PARITY_EN
            parity  <= 1'b0;
`endif
        end else if (accept) begin
            state   <= SHIFT;
            shreg   <= load_rest;
            cnt     <= '0;
            q       <= first_bit;
            q_valid <= 1'b1;
            q_last  <= 1'b0;
`ifdef PISO_PARITY_EN
            parity  <= ^din;
`endif
        end else if (state == SHIFT) begin
            if (cnt == LAST_IDX) begin
                state   <= IDLE;
                shreg   <= '0;
                cnt     <= '0;
                q       <= 1'b0;
                q_valid <= 1'b0;
                q_last  <= 1'b0;
            end else begin
                cnt     <= cnt_next;
                shreg   <= shift_rest;
                q_last  <= (cnt_next == LAST_IDX);
`ifdef PISO_PARITY_EN
                q       <= (cnt_next == CW'(WIDTH)) ? parity : next_bit;
`else
                q       <= next_bit;
`endif
            end
        end
    end

endmodule

// File: tb/tb_piso_serializer.sv
// Directed bench for piso_serializer: MSB-first and LSB-first instances share clk/rst.
// Expectations follow PISO_PARITY_EN when it is defined for the build.
module tb_piso_serializer;

`ifdef PISO_PARITY_EN
    localparam int N = 9;
`else
    localparam int N = 8;
`endif

    logic       clk;
    logic       rst;
    logic [7:0] din_m, din_l;
    logic       lv_m, lv_l;
    logic       lr_m, lr_l;
    logic       q_m, q_l;
    logic       qv_m, qv_l;
    logic       ql_m, ql_l;

    int checks = 0;
    int errors = 0;

    piso_serializer #(.WIDTH(8), .MSB_FIRST(1)) dut_m (
        .clk(clk), .rst(rst), .din(din_m), .load_valid(lv_m), .load_ready(lr_m),
        .q(q_m), .q_valid(qv_m), .q_last(ql_m)
    );

    piso_serializer #(.WIDTH(8), .MSB_FIRST(0)) dut_l (
        .clk(clk), .rst(rst), .din(din_l), .load_valid(lv_l), .load_ready(lr_l),
        .q(q_l), .q_valid(qv_l), .q_last(ql_l)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic obs, input logic want);
        checks++;
        assert (obs === want) else begin
            errors++;
            $error("FAIL %s observed %b expected %b at %0t", tag, obs, want, $time);
        end
    endtask

    task automatic chk_idle(input string tag, input bit lsb);
        chk({tag, "_q"},       lsb ? q_l  : q_m,  1'b0);
        chk({tag, "_q_valid"}, lsb ? qv_l : qv_m, 1'b0);
        chk({tag, "_q_last"},  lsb ? ql_l : ql_m, 1'b0);
        chk({tag, "_ready"},   lsb ? lr_l : lr_m, 1'b1);
    endtask

    // Called in cycle 1 of a frame; returns in cycle N without advancing past it.
    task automatic expect_frame(input string tag, input bit lsb, input logic [7:0] w, input bit disturb);
        for (int i = 0; i < N; i++) begin
            logic eb;
            if (i < 8) eb = lsb ? w[i] : w[7-i];
            else       eb = ^w;
            chk({tag, "_q"},       lsb ? q_l  : q_m,  eb);
            chk({tag, "_q_valid"}, lsb ? qv_l : qv_m, 1'b1);
            chk({tag, "_q_last"},  lsb ? ql_l : ql_m, (i == N-1));
            chk({tag, "_ready"},   lsb ? lr_l : lr_m, (i == N-1));
            if (i != N-1) begin
                if (disturb) begin
                    din_m = 8'h5A ^ 8'(i);
                    lv_m  = (i >= 1 && i <= 5) ? (i % 2 == 1) : 1'b0;
                end
                tick();
            end
        end
    endtask

    initial begin
        rst   = 1'b1;
        din_m = 8'h00; din_l = 8'h00;
        lv_m  = 1'b0;  lv_l  = 1'b0;

        // Reset state
        repeat (3) tick();
        chk_idle("rst_hold_m", 0);
        chk_idle("rst_hold_l", 1);
        rst = 1'b0;
        tick();
        chk("post_rst_qv0", qv_m, 1'b0);
        tick();
        chk("post_rst_qv1", qv_m, 1'b0);
        chk("post_rst_lqv", qv_l, 1'b0);

        // Single word MSB first
        din_m = 8'hA5; lv_m = 1'b1;
        tick();
        lv_m = 1'b0;
        expect_frame("msb_a5", 0, 8'hA5, 0);
        tick();
        chk_idle("msb_a5_end", 0);

        // Single word LSB first
        din_l = 8'hC1; lv_l = 1'b1;
        tick();
        lv_l = 1'b0;
        expect_frame("lsb_c1", 1, 8'hC1, 0);
        tick();
        chk_idle("lsb_c1_end", 1);

        // Back-to-back with load_valid held
        din_m = 8'hA5; lv_m = 1'b1;
        tick();
        din_m = 8'h3C;
        expect_frame("b2b_a5", 0, 8'hA5, 0);
        tick();
        lv_m = 1'b0;
        expect_frame("b2b_3c", 0, 8'h3C, 0);
        tick();
        chk_idle("b2b_end", 0);

        // load_valid and din wiggled while busy
        din_m = 8'hA5; lv_m = 1'b1;
        tick();
        lv_m = 1'b0;
        expect_frame("busy_a5", 0, 8'hA5, 1);
        tick();
        chk_idle("busy_end", 0);

        // Asynchronous abort at cycle 4
        din_m = 8'hA5; lv_m = 1'b1;
        tick();
        lv_m = 1'b0;
        repeat (3) tick();
        chk("abort_c4_qv", qv_m, 1'b1);
        chk("abort_c4_q",  q_m,  1'b0);
        #2 rst = 1'b1;
        #1;
        chk_idle("abort_now", 0);
        tick();
        rst = 1'b0;
        tick();
        chk("abort_rel_qv0", qv_m, 1'b0);
        tick();
        chk("abort_rel_qv1", qv_m, 1'b0);
        din_m = 8'hFF; lv_m = 1'b1;
        tick();
        lv_m = 1'b0;
        expect_frame("abort_ff", 0, 8'hFF, 0);
        tick();
        chk_idle("abort_ff_end", 0);

        // rst and accept together: nothing captured
        din_m = 8'hFF; lv_m = 1'b1; rst = 1'b1;
        tick();
        rst = 1'b0; lv_m = 1'b0;
        chk_idle("rst_acc0", 0);
        tick();
        chk_idle("rst_acc1", 0);

        // Odd-weight word exercises a parity bit of 1 when enabled
        din_m = 8'h07; lv_m = 1'b1;
        tick();
        lv_m = 1'b0;
        expect_frame("w07", 0, 8'h07, 0);
        tick();
        chk_idle("w07_end", 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
